// File: rtl/shared_data_stream_tx_if.sv
// AXI4-Lite bundle carrying local shared-memory writes into the TX block.
// Latency: none, wires only.
// Backpressure: standard valid/ready on every channel.
interface axi4_lite #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic            awvalid;
  logic            awready;
  logic [AW-1:0]   awaddr;
  logic            wvalid;
  logic            wready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [AW-1:0]   araddr;
  logic            rvalid;
  logic            rready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;

  modport s (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/shared_data_stream_tx.sv
// Buffers AXI4-Lite writes for one shared-memory segment and sends them as a framed TX byte stream.
// Latency: flush decision -> START state next cycle; one symbol per data_tx_ena cycle thereafter.
// Backpressure: writes stall while a frame is sending or a different segment is pending; TX stalls on data_tx_ena=0.
// Optional: SHARED_DATA_TX_TIMEOUT_EN adds the idle-timeout flush.
module shared_data_stream_tx #(
  parameter int FB_DW               = 32,
  parameter int SHARED_MEM_SEG_SIZE = 64,
  parameter int SHARED_MEM_AW       = 16,
  parameter int FLUSH_TIMEOUT       = 64
) (
  input  logic       clk,
  input  logic       rst,
  axi4_lite.s        shared_data_in_i,
  input  logic       data_tx_ena,
  output logic [7:0] tx_data,
  output logic       tx_isk,
  output logic       tx_busy
);
  localparam int WSZ      = FB_DW / 8;
  localparam int BUF_SIZE = SHARED_MEM_SEG_SIZE / WSZ;
  localparam int WORD_LSB = $clog2(WSZ);
  localparam int SEG_LSB  = $clog2(SHARED_MEM_SEG_SIZE);
  localparam int IDX_W    = SEG_LSB - WORD_LSB;
  localparam int BCNT_W   = $clog2(BUF_SIZE * WSZ);
  localparam int CNT_W    = $clog2(BUF_SIZE + 1);

  typedef enum logic [1:0] {ING_EMPTY, ING_COLLECT, ING_SENDING} ing_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_ADDR, TX_DATA, TX_STOP, TX_CHK_HI, TX_CHK_LO} tx_state_t;

  ing_state_t                      ing_q, ing_d;
  tx_state_t                       tx_q, tx_d;
  logic [7:0]                      pend_seg_q, pend_seg_d;
  logic [BUF_SIZE-1:0]             vld_q, vld_d;
  logic [BUF_SIZE-1:0][FB_DW-1:0]  mem_q, mem_d;
  logic [BCNT_W-1:0]               bc_q, bc_d;
  logic [15:0]                     chk_q, chk_d;
  logic                            bvalid_q, bvalid_d;
  logic [1:0]                      bresp_q, bresp_d;
  logic                            rvalid_q, rvalid_d;

  logic [SHARED_MEM_AW-1:0] seg_shift;
  logic [7:0]               wr_seg;
  logic [IDX_W-1:0]         wr_word;
  logic                     req, rsv, permit, accept, wr_buf, last_wr, flush;
  logic                     timeout_hit;
  logic [CNT_W-1:0]         word_cnt;
  logic [BCNT_W:0]          nbytes;
  logic [IDX_W-1:0]         cur_word;
  logic [WORD_LSB-1:0]      cur_lane;
  logic [7:0]               cur_byte;
  logic                     last_byte;

  assign seg_shift = shared_data_in_i.awaddr >> SEG_LSB;
  assign wr_seg    = seg_shift[7:0];
  assign wr_word   = shared_data_in_i.awaddr[SEG_LSB-1:WORD_LSB];
  assign req       = shared_data_in_i.awvalid && shared_data_in_i.wvalid && !bvalid_q;
  assign rsv       = (wr_seg == 8'hFF);

  // Only the low address bits and the read address carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{shared_data_in_i.araddr, shared_data_in_i.awaddr[WORD_LSB-1:0],
                       seg_shift[SHARED_MEM_AW-1:8]};

`ifdef SHARED_DATA_TX_TIMEOUT_EN
  localparam int TMR_W = $clog2(FLUSH_TIMEOUT + 1);
  logic [TMR_W-1:0] timer_q, timer_d;

  assign timeout_hit = (timer_q == TMR_W'(FLUSH_TIMEOUT));

  // Idle timer: cleared by every accepted write, saturates at the timeout.
  always_comb begin
    timer_d = timer_q;
    if (accept)            timer_d = '0;
    else if (!timeout_hit) timer_d = timer_q + 1'b1;
  end

  // Timer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo  = (FLUSH_TIMEOUT > 0);
  assign timeout_hit = 1'b0;
`endif

  // Frame length comes from the highest valid word; gaps below it go out as zeros.
  always_comb begin
    word_cnt = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (vld_q[i]) word_cnt = CNT_W'(i + 1);
    end
  end

  assign nbytes    = (BCNT_W + 1)'(word_cnt) << WORD_LSB;
  assign last_byte = ({1'b0, bc_q} == nbytes - 1'b1);
  assign cur_word  = bc_q[BCNT_W-1:WORD_LSB];
  assign cur_lane  = bc_q[WORD_LSB-1:0];
  assign cur_byte  = vld_q[cur_word] ? mem_q[cur_word][{cur_lane, 3'b000} +: 8] : 8'h00;

  // Ingest: write admission, buffer update and flush decision.
  always_comb begin
    ing_d      = ing_q;
    pend_seg_d = pend_seg_q;
    vld_d      = vld_q;
    mem_d      = mem_q;
    flush      = 1'b0;
    case (ing_q)
      ING_EMPTY:   permit = 1'b1;
      ING_COLLECT: permit = rsv || (wr_seg == pend_seg_q);
      default:     permit = 1'b0;
    endcase
    accept  = req && permit;
    wr_buf  = accept && !rsv;
    last_wr = wr_buf && (wr_word == IDX_W'(BUF_SIZE - 1));

    if (wr_buf) begin
      // First write to a word this frame clears lanes the strobe leaves untouched.
      if (!vld_q[wr_word]) mem_d[wr_word] = '0;
      for (int b = 0; b < WSZ; b++) begin
        if (shared_data_in_i.wstrb[b]) mem_d[wr_word][b*8 +: 8] = shared_data_in_i.wdata[b*8 +: 8];
      end
      vld_d[wr_word] = 1'b1;
    end

    case (ing_q)
      ING_EMPTY: begin
        if (wr_buf) begin
          pend_seg_d = wr_seg;
          flush      = last_wr;
          ing_d      = last_wr ? ING_SENDING : ING_COLLECT;
        end
      end
      ING_COLLECT: begin
        if (last_wr || (req && !permit) || timeout_hit) begin
          flush = 1'b1;
          ing_d = ING_SENDING;
        end
      end
      default: begin
        if (tx_q == TX_IDLE) begin
          ing_d = ING_EMPTY;
          vld_d = '0;
        end
      end
    endcase
  end

  // Response channels: B follows each accept, R answers every read with an error.
  always_comb begin
    bvalid_d = accept || (bvalid_q && !shared_data_in_i.bready);
    bresp_d  = accept ? (rsv ? 2'b10 : 2'b00) : bresp_q;
    rvalid_d = shared_data_in_i.arvalid || (rvalid_q && !shared_data_in_i.rready);
  end

  assign shared_data_in_i.awready = accept;
  assign shared_data_in_i.wready  = accept;
  assign shared_data_in_i.bvalid  = bvalid_q;
  assign shared_data_in_i.bresp   = bresp_q;
  assign shared_data_in_i.arready = 1'b1;
  assign shared_data_in_i.rvalid  = rvalid_q;
  assign shared_data_in_i.rdata   = '0;
  assign shared_data_in_i.rresp   = 2'b10;

  // TX FSM: next state, checksum update and combinational symbol output.
  always_comb begin
    tx_d    = tx_q;
    bc_d    = bc_q;
    chk_d   = chk_q;
    tx_data = 8'h00;
    tx_isk  = 1'b0;
    case (tx_q)
      TX_IDLE: begin
        if (flush) begin
          tx_d  = TX_START;
          bc_d  = '0;
          chk_d = 16'hFFFF;
        end
      end
      TX_START: if (data_tx_ena) begin
        tx_data = 8'h5C;
        tx_isk  = 1'b1;
        tx_d    = TX_ADDR;
      end
      TX_ADDR: if (data_tx_ena) begin
        tx_data = pend_seg_q;
        chk_d   = chk_q - {8'h00, pend_seg_q};
        tx_d    = TX_DATA;
      end
      TX_DATA: if (data_tx_ena) begin
        tx_data = cur_byte;
        chk_d   = chk_q - {8'h00, cur_byte};
        if (last_byte) tx_d = TX_STOP;
        else           bc_d = bc_q + 1'b1;
      end
      TX_STOP: if (data_tx_ena) begin
        tx_data = 8'h3C;
        tx_isk  = 1'b1;
        tx_d    = TX_CHK_HI;
      end
      TX_CHK_HI: if (data_tx_ena) begin
        tx_data = chk_q[15:8];
        tx_d    = TX_CHK_LO;
      end
      TX_CHK_LO: if (data_tx_ena) begin
        tx_data = chk_q[7:0];
        tx_d    = TX_IDLE;
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  assign tx_busy = (tx_q != TX_IDLE);

  // State registers; reset drops any frame in flight and all pending responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ing_q      <= ING_EMPTY;
      tx_q       <= TX_IDLE;
      pend_seg_q <= 8'h00;
      vld_q      <= '0;
      mem_q      <= '0;
      bc_q       <= '0;
      chk_q      <= 16'hFFFF;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
    end else begin
      ing_q      <= ing_d;
      tx_q       <= tx_d;
      pend_seg_q <= pend_seg_d;
      vld_q      <= vld_d;
      mem_q      <= mem_d;
      bc_q       <= bc_d;
      chk_q      <= chk_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
    end
  end
endmodule

// File: tb/tb_shared_data_stream_tx.sv
// Directed + randomized bench for shared_data_stream_tx with a byte-level frame model.
// Latency: frames checked symbol by symbol as they appear on enabled TX slots.
// Backpressure: exercises write stalls during sending and stretched data_tx_ena.
module tb_shared_data_stream_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_tx_ena = 1'b0;
  logic [7:0] tx_data;
  logic       tx_isk;
  logic       tx_busy;

  axi4_lite #(.AW(16), .DW(32)) axi ();

  shared_data_stream_tx #(
    .FB_DW(32), .SHARED_MEM_SEG_SIZE(64), .SHARED_MEM_AW(16), .FLUSH_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .shared_data_in_i(axi.s),
    .data_tx_ena(data_tx_ena), .tx_data(tx_data), .tx_isk(tx_isk), .tx_busy(tx_busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ena_mode = 0;
  int busy_cnt = 0;
  int idle_bad = 0;
  int fall_cyc = -1;
  int last_acc = -1;
  int last_stall = 0;
  logic busy_prev = 1'b0;
  logic [8:0] got[$];
  logic [8:0] exp_q[$];

  // Reference model of one segment: bytes per word plus a written flag.
  bit [7:0] mm[16][4];
  bit       mv[16];

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // TX slot strobe: tied high, every third cycle, or random.
  initial forever begin
    @(posedge clk);
    #1;
    case (ena_mode)
      0: data_tx_ena = 1'b1;
      1: data_tx_ena = (cyc % 3 == 0);
      default: data_tx_ena = 1'($urandom_range(0, 1));
    endcase
  end

  // Symbol capture on enabled busy slots; everything else must be zero.
  initial forever begin
    @(negedge clk);
    if (tx_busy && data_tx_ena) got.push_back({tx_isk, tx_data});
    else if (tx_data !== 8'h00 || tx_isk !== 1'b0) idle_bad++;
    if (tx_busy) busy_cnt++;
    if (busy_prev && !tx_busy) fall_cyc = cyc;
    busy_prev = tx_busy;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int w = 0; w < 16; w++) begin
      mv[w] = 1'b0;
      for (int b = 0; b < 4; b++) mm[w][b] = 8'h00;
    end
  endtask

  task automatic m_write(input int w, input logic [31:0] d, input logic [3:0] s);
    if (!mv[w]) for (int b = 0; b < 4; b++) mm[w][b] = 8'h00;
    for (int b = 0; b < 4; b++) if (s[b]) mm[w][b] = d[b*8 +: 8];
    mv[w] = 1'b1;
  endtask

  // Expected frame: K-start, address, bytes up to highest written word, K-stop, checksum.
  task automatic m_frame(input logic [7:0] seg);
    int hi;
    int sum;
    logic [15:0] ck;
    logic [7:0] by;
    exp_q.delete();
    hi = -1;
    for (int w = 0; w < 16; w++) if (mv[w]) hi = w;
    exp_q.push_back(9'h15C);
    exp_q.push_back({1'b0, seg});
    sum = seg;
    for (int w = 0; w <= hi; w++) begin
      for (int b = 0; b < 4; b++) begin
        by = mv[w] ? mm[w][b] : 8'h00;
        exp_q.push_back({1'b0, by});
        sum += by;
      end
    end
    exp_q.push_back(9'h13C);
    ck = 16'hFFFF - 16'(sum);
    exp_q.push_back({1'b0, ck[15:8]});
    exp_q.push_back({1'b0, ck[7:0]});
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic bv, output int acc, output int stall);
    logic ok;
    @(posedge clk);
    #1;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    ok = 1'b0; acc = -1; stall = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (axi.awready && axi.wready) begin
        ok = 1'b1; acc = cyc; break;
      end
      stall++;
    end
    chk("aw_accept", ok, 1);
    @(posedge clk);
    #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    @(negedge clk);
    resp = axi.bresp;
    bv = axi.bvalid;
  endtask

  task automatic wr(input logic [7:0] seg, input int w, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r;
    logic bv;
    int ac, st;
    axi_write((16'(seg) << 6) | 16'(w * 4), d, s, r, bv, ac, st);
    chk("bvalid", bv, 1);
    chk("bresp", r, (seg == 8'hFF) ? 2 : 0);
    if (seg != 8'hFF) m_write(w, d, s);
    last_acc = ac;
    last_stall = st;
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (!(got.size() >= exp_q.size() && !tx_busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk({tag, "_sym"}, got[i], exp_q[i]);
  endtask

  initial begin
    logic [15:0] ck_a;
    logic [31:0] d0, d1, d15;
    logic [7:0]  seg;
    int n;
    axi.awvalid = 0; axi.awaddr = 0; axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0;
    axi.bready = 1; axi.arvalid = 0; axi.araddr = 0; axi.rready = 1;
    m_clear();

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_awready", axi.awready, 0);
    chk("rst_wready", axi.wready, 0);
    chk("rst_bvalid", axi.bvalid, 0);
    chk("rst_rvalid", axi.rvalid, 0);
    chk("rst_arready", axi.arready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_isk", tx_isk, 0);
    chk("rst_data", tx_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef SHARED_DATA_TX_TIMEOUT_EN
    // Idle-timeout flush of a two-word segment.
    ena_mode = 0; got.delete(); busy_cnt = 0; m_clear();
    wr(8'd3, 0, 32'h04030201, 4'hF);
    wr(8'd3, 1, 32'h08070605, 4'hF);
    chk("tmo_early", busy_cnt, 0);
    m_frame(8'd3);
    wait_frame("timeout");
    chk("tmo_chk_lo", got[12], 9'h0D8);
    chk("tmo_busy", busy_cnt, 13);
`endif

    // Write to the last word flushes at once.
    ena_mode = 0; got.delete(); m_clear();
    wr(8'd1, 15, 32'h000000AA, 4'hF);
    m_frame(8'd1);
    wait_frame("lastword");
    chk("lastword_chk_hi", got[67], 9'h0FF);
    chk("lastword_chk_lo", got[68], 9'h054);

    // Different segment stalls until the pending frame has gone out.
    got.delete(); m_clear();
    wr(8'd2, 0, $urandom, 4'hF);
    m_frame(8'd2);
    m_clear();
    wr(8'd4, 0, 32'h11223344, 4'hF);
    wait_frame("segchg_old");
    chk("segchg_stalled", last_stall >= 9, 1);
    chk("segchg_acc_cycle", last_acc, fall_cyc + 1);
    got.delete();
    wr(8'd4, 15, $urandom, 4'hF);
    m_frame(8'd4);
    wait_frame("segchg_new");

    // Reserved segment: error response, no frame; reads always error.
    got.delete(); busy_cnt = 0; m_clear();
    wr(8'hFF, 3, 32'hDEADBEEF, 4'hF);
    wr(8'hFF, 15, 32'hCAFEF00D, 4'hF);
    repeat (100) @(negedge clk);
    chk("rsv_nobusy", busy_cnt, 0);
    chk("rsv_noframe", got.size(), 0);
    axi.rready = 0;
    @(posedge clk); #1 axi.arvalid = 1;
    @(negedge clk);
    chk("rd_arready", axi.arready, 1);
    @(posedge clk); #1 axi.arvalid = 0;
    @(negedge clk);
    chk("rd_rvalid", axi.rvalid, 1);
    chk("rd_rdata", axi.rdata, 0);
    chk("rd_rresp", axi.rresp, 2);
    @(negedge clk);
    chk("rd_hold", axi.rvalid, 1);
    @(posedge clk); #1 axi.rready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rd_done", axi.rvalid, 0);

    // Same frame with ena tied high and with ena every third cycle.
    d0 = $urandom; d1 = $urandom; d15 = $urandom;
    ena_mode = 0; got.delete(); m_clear();
    wr(8'd3, 0, d0, 4'hF); wr(8'd3, 1, d1, 4'hF); wr(8'd3, 15, d15, 4'hF);
    m_frame(8'd3);
    wait_frame("ena_full");
    ck_a = {got[got.size()-2][7:0], got[got.size()-1][7:0]};
    ena_mode = 1; got.delete(); m_clear();
    wr(8'd3, 0, d0, 4'hF); wr(8'd3, 1, d1, 4'hF); wr(8'd3, 15, d15, 4'hF);
    m_frame(8'd3);
    wait_frame("ena_third");
    chk("ena_same_chk", {got[got.size()-2][7:0], got[got.size()-1][7:0]}, ck_a);

    // Randomized segments, words, strobes and slot patterns.
    for (int it = 0; it < 6; it++) begin
      ena_mode = $urandom_range(0, 2);
      got.delete(); m_clear();
      seg = 8'($urandom_range(0, 254));
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        int w;
        w = $urandom_range(0, 14);
        wr(seg, w, $urandom, mv[w] ? 4'($urandom_range(1, 15)) : 4'hF);
      end
      wr(seg, 15, $urandom, 4'hF);
      m_frame(seg);
      wait_frame("random");
    end

    // Reset in the middle of the data bytes.
    ena_mode = 0; got.delete(); m_clear();
    wr(8'd5, 15, 32'h55667788, 4'hF);
    axi.rready = 0;
    @(posedge clk); #1 axi.arvalid = 1;
    @(posedge clk); #1 axi.arvalid = 0;
    n = 0;
    while (got.size() < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_in_data", got.size() >= 4 && tx_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_data", tx_data, 0);
    chk("midrst_isk", tx_isk, 0);
    chk("midrst_rvalid", axi.rvalid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    axi.rready = 1;
    got.delete(); m_clear();
    wr(8'd6, 15, 32'h000000AA, 4'hF);
    m_frame(8'd6);
    wait_frame("after_rst");
    chk("after_rst_chk_lo", got[got.size()-1], 9'h04F);

    chk("idle_zero", idle_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
